// File: rtl/fan_power_scheduler.sv
// fan_power_scheduler: button-driven fan speed sequencer with 100/200 ms tick strobes,
// low-battery derate with hysteresis, empty-battery lockout and a registered charge qualifier.
module fan_power_scheduler #(
    parameter int TICK_DIV    = 5000000,
    parameter int LOW_BATT    = 20,
    parameter int RESUME_BATT = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_off,
    input  logic       sw0,
    input  logic [7:0] battery,
    input  logic       battery_empty,
    output logic [1:0] state,
    output logic       timer_100ms,
    output logic       timer_200ms,
    output logic       low_batt,
    output logic       fan_lock,
    output logic       charge_en
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [7:0] LOW = 8'(LOW_BATT);
    localparam logic [7:0] RESUME = 8'(RESUME_BATT);

    typedef enum logic [2:0] {
        NEUTRAL = 3'd0,
        SPD1    = 3'd1,
        SPD2    = 3'd2,
        SPD3    = 3'd3,
        LOCKED  = 3'd4
    } fsm_t;

    fsm_t fsm_q, fsm_d;
    logic [CW-1:0] cnt;
    logic phase, wrap;
    logic up_q, down_q, off_q;
    logic press_up, press_down, press_off;
    logic [1:0] lvl, cap, lvl_up, lvl_down;

    assign wrap       = cnt == LAST;
    assign press_up   = btn_up & ~up_q;
    assign press_down = btn_down & ~down_q;
    assign press_off  = btn_off & ~off_q;

    // Ticks run free of the FSM; the 200 ms strobe rides on every second wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            phase       <= 1'b0;
            timer_100ms <= 1'b0;
            timer_200ms <= 1'b0;
        end else begin
            timer_100ms <= wrap;
            timer_200ms <= wrap & phase;
            cnt         <= wrap ? '0 : cnt + 1'b1;
            phase       <= wrap ? ~phase : phase;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            off_q     <= 1'b0;
            low_batt  <= 1'b0;
            charge_en <= 1'b0;
        end else begin
            up_q      <= btn_up;
            down_q    <= btn_down;
            off_q     <= btn_off;
            low_batt  <= (battery <= LOW) ? 1'b1 : (battery >= RESUME) ? 1'b0 : low_batt;
            charge_en <= sw0 & (battery < 8'd99);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) fsm_q <= NEUTRAL;
        else     fsm_q <= fsm_d;
    end

    // Cap uses the registered low_batt, so derate lands one cycle after the flag rises.
    always_comb begin
        lvl      = fsm_q[1:0];
        cap      = low_batt ? 2'd1 : 2'd3;
        lvl_up   = (lvl >= cap) ? cap : lvl + 2'd1;
        lvl_down = (lvl == 2'd0) ? 2'd0 : lvl - 2'd1;
        fsm_d    = fsm_q;
        if (battery_empty)
            fsm_d = LOCKED;
        else if (fsm_q == LOCKED)
            fsm_d = (battery >= RESUME) ? NEUTRAL : LOCKED;
        else if (press_off)
            fsm_d = NEUTRAL;
        else if (press_down)
            fsm_d = fsm_t'({1'b0, lvl_down});
        else if (press_up)
            fsm_d = fsm_t'({1'b0, lvl_up});
        else if (low_batt && lvl[1])
            fsm_d = SPD1;
    end

    always_comb begin
        state    = (fsm_q == LOCKED) ? 2'b00 : fsm_q[1:0];
        fan_lock = fsm_q == LOCKED;
    end
endmodule

// File: tb/tb_fan_power_scheduler.sv
// tb_fan_power_scheduler: directed scenarios plus randomized run against a cycle-level
// arithmetic model of the fan sequencer (ticks from elapsed cycles, speed as an integer).
module tb_fan_power_scheduler;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_off = 1'b0, sw0 = 1'b0;
    logic [7:0] battery = 8'd80;
    logic battery_empty = 1'b0;
    logic [1:0] state;
    logic timer_100ms, timer_200ms, low_batt, fan_lock, charge_en;

    int vectors = 0, errors = 0;

    // reference model
    int n = 0, spd = 0;
    bit lock = 0, lb = 0, ce = 0, uq = 0, dq = 0, oq = 0;

    fan_power_scheduler #(.TICK_DIV(TD), .LOW_BATT(20), .RESUME_BATT(30)) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_off(btn_off),
        .sw0(sw0), .battery(battery), .battery_empty(battery_empty), .state(state),
        .timer_100ms(timer_100ms), .timer_200ms(timer_200ms), .low_batt(low_batt),
        .fan_lock(fan_lock), .charge_en(charge_en)
    );

    always #5 clk = ~clk;

    // Advance one clock: the model consumes the inputs as they stand at the edge.
    task automatic cyc();
        bit pu, pd, po;
        int cap;
        if (rst) begin
            n = 0; spd = 0; lock = 0; lb = 0; ce = 0; uq = 0; dq = 0; oq = 0;
        end else begin
            n++;
            pu = btn_up && !uq; pd = btn_down && !dq; po = btn_off && !oq;
            cap = lb ? 1 : 3;
            if (battery_empty) begin
                lock = 1; spd = 0;
            end else if (lock) begin
                if (battery >= 30) lock = 0;
            end else if (po) spd = 0;
            else if (pd) spd = (spd > 0) ? spd - 1 : 0;
            else if (pu) spd = (spd + 1 > cap) ? cap : spd + 1;
            else if (lb && spd >= 2) spd = 1;
            if (battery <= 20) lb = 1;
            else if (battery >= 30) lb = 0;
            ce = sw0 && (battery < 99);
            uq = btn_up; dq = btn_down; oq = btn_off;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        battery = 8'd80; sw0 = 1'b0; battery_empty = 1'b0;
        rst = 1'b1; cyc(); rst = 1'b0;
        vectors++;
        if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", state); end
        vectors++;
        if ({timer_100ms, timer_200ms, low_batt, fan_lock, charge_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000", {timer_100ms, timer_200ms, low_batt, fan_lock, charge_en});
        end
    endtask

    task automatic test_ticks();
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            vectors++;
            if (timer_100ms !== (i % 4 == 0)) begin
                errors++; $display("FAIL tick100 cycle %0d got %b exp %b", i, timer_100ms, i % 4 == 0);
            end
            vectors++;
            if (timer_200ms !== (i % 8 == 0)) begin
                errors++; $display("FAIL tick200 cycle %0d got %b exp %b", i, timer_200ms, i % 8 == 0);
            end
        end
    endtask

    task automatic test_stepping();
        logic [1:0] exp_s [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        battery = 8'd80;
        for (int i = 0; i < 4; i++) begin
            btn_up = 1'b1; cyc(); btn_up = 1'b0;
            vectors++;
            if (state !== exp_s[i]) begin errors++; $display("FAIL step_up %0d got %b exp %b", i, state, exp_s[i]); end
            cyc(); cyc();
        end
        btn_down = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            vectors++;
            if (state !== 2'd2) begin errors++; $display("FAIL step_down_hold %0d got %b exp 10", i, state); end
        end
        btn_down = 1'b0; cyc();
    endtask

    task automatic test_simultaneous();
        btn_up = 1'b1; btn_down = 1'b1; cyc(); btn_up = 1'b0; btn_down = 1'b0;
        vectors++;
        if (state !== 2'd1) begin errors++; $display("FAIL sim_up_down got %b exp 01", state); end
        cyc();
        btn_up = 1'b1; btn_off = 1'b1; cyc(); btn_up = 1'b0; btn_off = 1'b0;
        vectors++;
        if (state !== 2'd0) begin errors++; $display("FAIL sim_off_up got %b exp 00", state); end
        cyc();
    endtask

    task automatic test_low_batt();
        for (int i = 0; i < 3; i++) begin btn_up = 1'b1; cyc(); btn_up = 1'b0; cyc(); end
        vectors++;
        if (state !== 2'd3) begin errors++; $display("FAIL lb_setup got %b exp 11", state); end
        battery = 8'd21; cyc();
        battery = 8'd20; cyc();
        vectors++;
        if (low_batt !== 1'b1 || state !== 2'd3) begin
            errors++; $display("FAIL lb_set got lb=%b st=%b exp lb=1 st=11", low_batt, state);
        end
        cyc();
        vectors++;
        if (state !== 2'd1) begin errors++; $display("FAIL lb_derate got %b exp 01", state); end
        btn_up = 1'b1; cyc(); btn_up = 1'b0;
        vectors++;
        if (state !== 2'd1) begin errors++; $display("FAIL lb_cap got %b exp 01", state); end
        battery = 8'd25; cyc();
        vectors++;
        if (low_batt !== 1'b1) begin errors++; $display("FAIL lb_hold got %b exp 1", low_batt); end
        battery = 8'd30; cyc();
        vectors++;
        if (low_batt !== 1'b0) begin errors++; $display("FAIL lb_clear got %b exp 0", low_batt); end
        btn_up = 1'b1; cyc(); btn_up = 1'b0;
        vectors++;
        if (state !== 2'd2) begin errors++; $display("FAIL lb_resume_up got %b exp 10", state); end
        cyc();
    endtask

    task automatic test_lockout();
        battery_empty = 1'b1; cyc();
        vectors++;
        if (state !== 2'd0 || fan_lock !== 1'b1) begin
            errors++; $display("FAIL lock_enter got st=%b lock=%b exp st=00 lock=1", state, fan_lock);
        end
        btn_up = 1'b1; cyc(); btn_up = 1'b0;
        vectors++;
        if (state !== 2'd0 || fan_lock !== 1'b1) begin
            errors++; $display("FAIL lock_ignore_up got st=%b lock=%b exp st=00 lock=1", state, fan_lock);
        end
        battery_empty = 1'b0; battery = 8'd29; cyc();
        vectors++;
        if (fan_lock !== 1'b1) begin errors++; $display("FAIL lock_hold29 got %b exp 1", fan_lock); end
        battery = 8'd30; cyc();
        vectors++;
        if (state !== 2'd0 || fan_lock !== 1'b0) begin
            errors++; $display("FAIL lock_exit got st=%b lock=%b exp st=00 lock=0", state, fan_lock);
        end
        btn_up = 1'b1; cyc(); btn_up = 1'b0;
        vectors++;
        if (state !== 2'd1) begin errors++; $display("FAIL lock_after_up got %b exp 01", state); end
        cyc();
    endtask

    task automatic test_charge_reset();
        sw0 = 1'b1; battery = 8'd98; cyc();
        vectors++;
        if (charge_en !== 1'b1) begin errors++; $display("FAIL charge_98 got %b exp 1", charge_en); end
        battery = 8'd99; cyc();
        vectors++;
        if (charge_en !== 1'b0) begin errors++; $display("FAIL charge_99 got %b exp 0", charge_en); end
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin btn_up = 1'b1; cyc(); btn_up = 1'b0; cyc(); end
        vectors++;
        if (state !== 2'd3) begin errors++; $display("FAIL midrst_setup got %b exp 11", state); end
        rst = 1'b1; cyc(); rst = 1'b0;
        vectors++;
        if (state !== 2'd0 || {timer_100ms, timer_200ms, low_batt, fan_lock, charge_en} !== 5'b0) begin
            errors++;
            $display("FAIL midrst_clear got st=%b flags=%b exp st=00 flags=00000", state,
                     {timer_100ms, timer_200ms, low_batt, fan_lock, charge_en});
        end
        for (int i = 1; i <= TD; i++) begin
            cyc();
            vectors++;
            if (timer_100ms !== (i == TD)) begin
                errors++; $display("FAIL midrst_tick cycle %0d got %b exp %b", i, timer_100ms, i == TD);
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom % 150) == 0;
            btn_up = ($urandom % 3) == 0;
            btn_down = ($urandom % 5) == 0;
            btn_off = ($urandom % 12) == 0;
            sw0 = $urandom % 2;
            battery_empty = ($urandom % 40) == 0;
            r = $urandom % 10;
            if (r < 5) battery = 8'($urandom_range(17, 33));
            else if (r < 7) battery = 8'($urandom_range(97, 101));
            else if (r < 8) battery = 8'($urandom_range(200, 255));
            else battery = 8'($urandom_range(0, 99));
            cyc();
            vectors++;
            if (state !== 2'(lock ? 0 : spd)) begin
                errors++; $display("FAIL rnd_state %0d got %b exp %0d", i, state, lock ? 0 : spd);
            end
            vectors++;
            if (fan_lock !== lock || low_batt !== lb || charge_en !== ce) begin
                errors++;
                $display("FAIL rnd_flags %0d got lock=%b lb=%b ce=%b exp lock=%b lb=%b ce=%b",
                         i, fan_lock, low_batt, charge_en, lock, lb, ce);
            end
            vectors++;
            if (timer_100ms !== (n > 0 && n % TD == 0) || timer_200ms !== (n > 0 && n % (2 * TD) == 0)) begin
                errors++;
                $display("FAIL rnd_ticks %0d got t100=%b t200=%b exp t100=%b t200=%b", i, timer_100ms,
                         timer_200ms, n > 0 && n % TD == 0, n > 0 && n % (2 * TD) == 0);
            end
        end
        rst = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_off = 1'b0; battery_empty = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ticks();
        test_stepping();
        test_simultaneous();
        test_low_batt();
        test_lockout();
        test_charge_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
